// File: rtl/llr_pair_loader.sv
// llr_pair_loader
//   Front end of the polar SC decoder. Channel LLRs arrive one per cycle in
//   frame order. Each is saturated to the internal width. The first half of
//   each N-length frame is buffered. Each second-half LLR is then emitted
//   together with its buffered partner as the pair (llr[i], llr[i+N/2]),
//   which feeds the stage-0 F/G node units.
//
// Ports
//   clk, rst        : single clock; synchronous active-high reset
//   in_valid        : channel LLR valid
//   in_ready        : block can accept a channel LLR
//   in_llr          : signed channel LLR (CH_LLR_WIDTH bits)
//   out_valid       : pair valid
//   out_ready       : downstream accepts the pair
//   llr_out0        : saturated llr[i]        (x operand of F/G)
//   llr_out1        : saturated llr[i+HALF]   (y operand of F/G)
//   out_idx         : pair index i
//   out_last        : high on pair i = HALF-1
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Valid never depends on ready. Once out_valid is raised, the output
// payload stays frozen until it is accepted. in_llr is only sampled on an
// input transfer.
module llr_pair_loader #(
    parameter int CH_LLR_WIDTH    = 8,
    parameter int INTER_LLR_WIDTH = 6,
    parameter int N               = 64,
    localparam int HALF           = N / 2,
    localparam int IDX_W          = $clog2(HALF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CH_LLR_WIDTH-1:0]    in_llr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INTER_LLR_WIDTH-1:0] llr_out0,
    output logic [INTER_LLR_WIDTH-1:0] llr_out1,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last
);

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_t;

    // Symmetric saturation bounds, expressed at the channel width so the
    // comparisons are done without losing any input bits.
    localparam int SAT_MAX_I = 2 ** (INTER_LLR_WIDTH - 1) - 1;
    localparam logic signed [CH_LLR_WIDTH-1:0] SAT_MAX = CH_LLR_WIDTH'(SAT_MAX_I);
    localparam logic signed [CH_LLR_WIDTH-1:0] SAT_MIN = CH_LLR_WIDTH'(-SAT_MAX_I);

    state_t                     state_q;
    state_t                     state_d;
    logic [IDX_W-1:0]           cnt;
    logic [INTER_LLR_WIDTH-1:0] llr_buf [HALF];
    logic [INTER_LLR_WIDTH-1:0] sat_llr;
    logic                       in_hs;
    logic                       cnt_last;

    // The most-negative internal code is never produced. This lets the F
    // unit negate |x| without overflow.
    always_comb begin
        sat_llr = in_llr[INTER_LLR_WIDTH-1:0];
        if ($signed(in_llr) > SAT_MAX) begin
            sat_llr = SAT_MAX[INTER_LLR_WIDTH-1:0];
        end else if ($signed(in_llr) < SAT_MIN) begin
            sat_llr = SAT_MIN[INTER_LLR_WIDTH-1:0];
        end
    end

    assign cnt_last = (cnt == IDX_W'(HALF - 1));
    assign in_hs    = in_valid && in_ready;

    // In FILL, inputs only go to the buffer, so a stalled output never
    // blocks them. In PAIR, each input loads the output register, so it can
    // only be taken when that register is empty or is being drained.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        if (!rst) begin
            if (state_q == FILL) begin
                in_ready = 1'b1;
            end else begin
                in_ready = !out_valid || out_ready;
            end
        end
        if (in_hs && cnt_last) begin
            state_d = (state_q == FILL) ? PAIR : FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt       <= '0;
            out_valid <= 1'b0;
            llr_out0  <= '0;
            llr_out1  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            state_q <= state_d;
            // HALF is a power of two, so the counter wraps to 0 after HALF-1.
            if (in_hs) begin
                cnt <= cnt + 1'b1;
            end
            if (state_q == PAIR && in_hs) begin
                llr_out0  <= llr_buf[cnt];
                llr_out1  <= sat_llr;
                out_idx   <= cnt;
                out_last  <= cnt_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // The buffer is not reset. After a reset, every slot is rewritten in
    // FILL before PAIR reads it.
    always_ff @(posedge clk) begin
        if (state_q == FILL && in_hs) begin
            llr_buf[cnt] <= sat_llr;
        end
    end

endmodule

// File: tb/tb_llr_pair_loader.sv
module tb_llr_pair_loader;

  localparam int CH    = 8;
  localparam int W     = 6;
  localparam int NN    = 8;
  localparam int HALF  = NN / 2;
  localparam int IDX_W = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [CH-1:0]    in_llr;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     llr_out0;
  logic [W-1:0]     llr_out1;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  llr_pair_loader #(
    .CH_LLR_WIDTH    (CH),
    .INTER_LLR_WIDTH (W),
    .N               (NN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_llr    (in_llr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .llr_out0  (llr_out0),
    .llr_out1  (llr_out1),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  // scoreboard: {idx, last, llr0, llr1}
  logic [IDX_W+1+2*W-1:0] exp_q[$];
  int n_asserts = 0;
  int n_fail    = 0;

  // reference model state
  bit         m_pair;
  bit         m_ov;
  int         m_pos;
  logic [W-1:0] m_half [HALF];

  function automatic logic [W-1:0] ref_sat(input logic [CH-1:0] raw);
    int v;
    v = int'($signed(raw));
    if (v > 31) v = 31;
    else if (v < -31) v = -31;
    return v[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_pair = 1'b0;
    m_ov   = 1'b0;
    m_pos  = 0;
  endtask

  // Hold reset for n cycles. The outputs are checked from the second cycle
  // onward, after the first reset edge.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst       = 1'b1;
      in_valid  = 1'($urandom_range(0, 1));
      in_llr    = 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rst_in_ready", in_ready, 0);
      if (i > 0) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_llr_out0", llr_out0, 0);
        chk("rst_llr_out1", llr_out1, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
      end
      @(negedge clk);
    end
    model_clear();
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle(input bit v, input logic [CH-1:0] llr, input bit ordy);
    logic                   exp_rdy;
    bit                     in_hs;
    bit                     load;
    logic [W-1:0]           s;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W+1+2*W-1:0] e;
    rst       = 1'b0;
    in_valid  = v;
    in_llr    = llr;
    out_ready = ordy;
    #1;
    exp_rdy = !m_pair || !m_ov || ordy;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_ov);
    if (m_ov && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("out_idx", out_idx, e[IDX_W+2*W:2*W+1]);
      chk("out_last", out_last, e[2*W]);
      chk("llr_out0", llr_out0, e[2*W-1:W]);
      chk("llr_out1", llr_out1, e[W-1:0]);
    end
    in_hs = v && exp_rdy;
    load  = m_pair && in_hs;
    if (m_ov && ordy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (in_hs) begin
      s = ref_sat(llr);
      if (m_pos < HALF) begin
        m_half[m_pos] = s;
      end else begin
        idx = IDX_W'(m_pos - HALF);
        exp_q.push_back({idx, (m_pos == NN - 1), m_half[m_pos - HALF], s});
      end
      m_pos  = (m_pos + 1) % NN;
      m_pair = (m_pos >= HALF);
    end
    m_ov = load ? 1'b1 : (ordy ? 1'b0 : m_ov);
    @(negedge clk);
  endtask

  logic [CH-1:0] sat_vals [NN];

  initial begin
    sat_vals = '{8'd100, 8'h9C, 8'hE0, 8'h80, 8'hE1, 8'd31, 8'd32, 8'd127};
    rst = 1'b1; in_valid = 1'b0; in_llr = '0; out_ready = 1'b0;
    model_clear();

    // initial reset
    do_reset(3);

    // pairing order: two back-to-back frames of in-range values
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NN; i++) cycle(1'b1, 8'(f * 8 + i), 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // saturation: 100, -100, -32, -128, -31, 31, 32, 127
    for (int i = 0; i < NN; i++) cycle(1'b1, sat_vals[i], 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // backpressure: stall 5 cycles in PAIR with in_valid held high
    for (int i = 0; i < HALF + 2; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // frame overlap: B fills while A's last pair is stalled
    for (int i = 0; i < NN; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < HALF; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < HALF; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // random gaps on both sides
    for (int i = 0; i < 80; i++)
      cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));

    // reset mid-PAIR after 2 of 4 pairs, then a fresh frame
    do_reset(2);
    for (int i = 0; i < HALF + 2; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    do_reset(3);
    for (int i = 0; i < NN; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);

    // drain
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/llr_pair_loader.md
# llr_pair_loader

- Front end of the polar SC decoder. Accepts one channel LLR per cycle and saturates it to the internal LLR width.
- Buffers the first half of each N-length frame. As each second-half LLR arrives, it emits the pair (llr[i], llr[i+N/2]) to the stage-0 F/G node units, which compute F(x,y) = sgn(x)sgn(y)min(|x|,|y|) and G.
- Saturation is symmetric (never the most-negative code), so the F unit's two's-complement negation of |x| cannot overflow.

## Interface
Parameters:
- CH_LLR_WIDTH, 8: width of the signed channel LLR input. Must be >= INTER_LLR_WIDTH.
- INTER_LLR_WIDTH, 6: width of the signed internal LLR. Must match the F/G units.
- N, 64: frame length; a power of two, >= 4.
- HALF = N/2 (derived); IDX_W = log2(HALF) (derived).

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: reset; synchronous and active-high.
- in_valid, input, 1: channel LLR valid.
- in_ready, output, 1: block can accept a channel LLR.
- in_llr, input, CH_LLR_WIDTH: signed channel LLR, in frame order 0..N-1.
- out_valid, output, 1: pair valid.
- out_ready, input, 1: downstream accepts the pair.
- llr_out0, output, INTER_LLR_WIDTH: saturated llr[i] (x operand of F/G).
- llr_out1, output, INTER_LLR_WIDTH: saturated llr[i+HALF] (y operand).
- out_idx, output, IDX_W: pair index i.
- out_last, output, 1: high on pair i = HALF-1.

## Operation
- Saturation (combinational on in_llr): MAX = 2^(INTER_LLR_WIDTH-1)-1.
  - in_llr > MAX gives MAX.
  - in_llr < -MAX gives -MAX.
  - Otherwise the low INTER_LLR_WIDTH bits.
  - The code -2^(INTER_LLR_WIDTH-1) is never produced.
- Storage: HALF x INTER_LLR_WIDTH register array buf, plus an IDX_W-bit counter cnt.
- FSM states: FILL and PAIR.
- FILL:
  - in_ready = 1.
  - On an input handshake: buf[cnt] <= sat(in_llr) and cnt increments.
  - At cnt = HALF-1 with a handshake: cnt <= 0 and go to PAIR.
- PAIR:
  - in_ready = !out_valid || out_ready (combinational).
  - On an input handshake, the output register loads llr_out0 <= buf[cnt], llr_out1 <= sat(in_llr), out_idx <= cnt, out_last <= (cnt == HALF-1), out_valid <= 1, and cnt increments.
  - At cnt = HALF-1 with a handshake: cnt <= 0 and go to FILL.
- Output register:
  - Holds all values stable while out_valid && !out_ready.
  - Clears out_valid on out_ready when no new load occurs in the same cycle.
- Returning to FILL while the last pair is still pending is legal. The pending pair is already registered, so buf may be overwritten by the next frame.
- rst (checked every cycle, takes precedence over everything): state <= FILL, cnt <= 0, out_valid <= 0, llr_out0/llr_out1/out_idx <= 0, out_last <= 0. buf is not cleared.
- A reset mid-frame discards the partial frame and any pending pair. The next accepted input is treated as llr[0].

## Timing
- Reset values of outputs: out_valid 0, llr_out0 0, llr_out1 0, out_idx 0, out_last 0.
- in_ready is 0 while rst is high, and 1 in the cycle after rst deasserts (FILL).
- Input handshake: in_valid && in_ready at a rising edge.
- Output handshake: out_valid && out_ready at a rising edge.
- Latency: an input handshake in PAIR at edge t gives out_valid high after edge t, i.e. the pair is visible in the cycle after t. Latency is one cycle; there is no combinational path from in_llr to any output.
- Throughput: one pair per cycle when in_valid = out_ready = 1 throughout PAIR.
- Frame time with no stalls: N cycles, namely HALF FILL cycles (no output) and HALF PAIR cycles.
- Simultaneous events:
  - In PAIR with out_valid = 1 and out_ready = 1 and an input handshake, the register reloads and out_valid stays 1 (no bubble).
  - out_ready = 0 with out_valid = 1 forces in_ready = 0 in PAIR.
  - out_ready = 0 does not affect FILL.
- in_llr is sampled only on a handshake; its value is ignored otherwise.

## Test plan
- Reset and idle: assert rst for 3 cycles mid-stream.
  - During reset: in_ready = 0 and all outputs = 0.
  - After reset: in_ready = 1 and out_valid = 0.
- Saturation (CH=8, W=6, N=4), frame {100, -100, -31, 31}:
  - Pair 0: llr_out0 = 31, llr_out1 = -31 (6'b100001).
  - Pair 1: llr_out0 = -31, llr_out1 = 31.
  - Inputs of -32 and -128 also produce -31; out_last is high on pair 1.
- Pairing order (N=8), inputs 0..7 (all in range):
  - Pairs (0,4), (1,5), (2,6), (3,7) with out_idx 0..3.
  - Each pair appears one cycle after its second-half input.
  - 8 cycles per frame back to back.
- Backpressure: hold out_ready = 0 for 5 cycles during PAIR.
  - in_ready = 0 and the outputs hold stable throughout.
  - On release, the remaining pairs follow one per cycle with no loss or duplication.
- Frame overlap: start frame B FILL while frame A's last pair is stalled.
  - A's last pair is unchanged.
  - B's pairs use only B's data.
- Reset mid-PAIR (after 2 of 4 pairs, N=8):
  - out_valid drops to 0.
  - The next 8 inputs form a fresh frame starting at out_idx 0.
